mips_mem_arbiter: RTL and testbench

- Shares one single-port memory bus (Avalon-style, with waitrequest) between the CPU's instruction-fetch port and data port.
- Lets the Harvard core run against a unified RAM.
- Sequences one transaction at a time, gives data accesses priority over fetches, and returns per-port valid pulses.
- Drives a stall line back to the core.

---
 rtl/mips_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port memory bus arbiter for a Harvard MIPS core's fetch and data ports
module mips_mem_arbiter #(
    parameter int TIMEOUT   = 256,
    parameter int TIMEOUT_W = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    input  logic        instr_read,
    output logic [31:0] instr_readdata,
    output logic        instr_valid,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_valid,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        cpu_stall,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        I_BUSY = 2'd2
    } state_t;

    // Value of the stall counter on the last waitrequest-high cycle before abort.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [31:0]    mem_address_q, mem_address_d;
    logic           mem_read_q, mem_read_d;
    logic           mem_write_q, mem_write_d;
    logic [31:0]    mem_writedata_q, mem_writedata_d;
    logic [3:0]     mem_byteenable_q, mem_byteenable_d;
    logic [31:0]    instr_readdata_q, instr_readdata_d;
    logic [31:0]    data_readdata_q, data_readdata_d;
    logic           instr_valid_q, instr_valid_d;
    logic           data_valid_q, data_valid_d;
    logic           bus_error_q, bus_error_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    logic data_req;
    logic instr_req;
    logic tmo_hit;

    // A port whose valid is high this cycle is still holding the request it just had served.
    assign data_req  = (data_read | data_write) & ~data_valid_q;
    assign instr_req = instr_read & ~instr_valid_q;
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

    // Next-state and registered-output logic: grant in IDLE, wait for the bus in BUSY.
    always_comb begin
        state_d          = state_q;
        mem_address_d    = mem_address_q;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_writedata_d  = mem_writedata_q;
        mem_byteenable_d = mem_byteenable_q;
        instr_readdata_d = instr_readdata_q;
        data_readdata_d  = data_readdata_q;
        instr_valid_d    = 1'b0;
        data_valid_d     = 1'b0;
        bus_error_d      = bus_error_q;
        tmo_d            = tmo_q;

        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (data_req) begin
                    // A simultaneous read and write is served as the write.
                    state_d          = D_BUSY;
                    mem_address_d    = data_address;
                    mem_write_d      = data_write;
                    mem_read_d       = ~data_write;
                    mem_writedata_d  = data_writedata;
                    mem_byteenable_d = data_write ? data_byteenable : 4'b1111;
                    if (data_read & data_write) begin
                        bus_error_d = 1'b1;
                    end
                end else if (instr_req) begin
                    state_d          = I_BUSY;
                    mem_address_d    = instr_address;
                    mem_read_d       = 1'b1;
                    mem_write_d      = 1'b0;
                    mem_writedata_d  = '0;
                    mem_byteenable_d = 4'b1111;
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            D_BUSY, I_BUSY: begin
                if (!mem_waitrequest) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    tmo_d       = '0;
                    if (state_q == D_BUSY) begin
                        data_valid_d = 1'b1;
                        if (mem_read_q) begin
                            data_readdata_d = mem_readdata;
                        end
                    end else begin
                        instr_valid_d    = 1'b1;
                        instr_readdata_d = mem_readdata;
                    end
                end else if (tmo_hit) begin
                    // Abort: the core gets all-ones and the sticky error is raised.
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    tmo_d       = '0;
                    bus_error_d = 1'b1;
                    if (state_q == D_BUSY) begin
                        data_valid_d    = 1'b1;
                        data_readdata_d = 32'hFFFF_FFFF;
                    end else begin
                        instr_valid_d    = 1'b1;
                        instr_readdata_d = 32'hFFFF_FFFF;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            mem_address_q    <= '0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
            mem_byteenable_q <= '0;
            instr_readdata_q <= '0;
            data_readdata_q  <= '0;
            instr_valid_q    <= 1'b0;
            data_valid_q     <= 1'b0;
            bus_error_q      <= 1'b0;
            tmo_q            <= '0;
        end else begin
            state_q          <= state_d;
            mem_address_q    <= mem_address_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
            mem_byteenable_q <= mem_byteenable_d;
            instr_readdata_q <= instr_readdata_d;
            data_readdata_q  <= data_readdata_d;
            instr_valid_q    <= instr_valid_d;
            data_valid_q     <= data_valid_d;
            bus_error_q      <= bus_error_d;
            tmo_q            <= tmo_d;
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_byteenable = mem_byteenable_q;
    assign instr_readdata = instr_readdata_q;
    assign data_readdata  = data_readdata_q;
    assign instr_valid    = instr_valid_q;
    assign data_valid     = data_valid_q;
    assign bus_error      = bus_error_q;

    assign cpu_stall = ~reset & ((instr_read & ~instr_valid_q) |
                                 ((data_read | data_write) & ~data_valid_q));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - self-checking bench for mips_mem_arbiter
module tb_mips_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_readdata;
    logic        instr_valid;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_valid;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        cpu_stall;
    logic        bus_error;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    mips_mem_arbiter #(.TIMEOUT(TMO), .TIMEOUT_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_address   (instr_address),
        .instr_read      (instr_read),
        .instr_readdata  (instr_readdata),
        .instr_valid     (instr_valid),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .data_valid      (data_valid),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest),
        .cpu_stall       (cpu_stall),
        .bus_error       (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: one outstanding bus access at most.
    typedef struct {
        bit          active;
        bit          is_data;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waited;
    } txn_t;

    txn_t        cur;
    logic        m_iv, m_dv, m_err;
    logic [31:0] m_ird, m_drd;

    always @(posedge clk) begin : model
        bit          iv_n, dv_n, abort;
        logic [31:0] r;
        if (reset) begin
            cur.active = 1'b0;
            cur.waited = 0;
            m_iv = 1'b0; m_dv = 1'b0; m_err = 1'b0;
            m_ird = '0;  m_drd = '0;
        end else begin
            iv_n = 1'b0;
            dv_n = 1'b0;
            if (cur.active) begin
                if (!mem_waitrequest || (TMO > 0 && cur.waited + 1 >= TMO)) begin
                    abort = mem_waitrequest;
                    r = abort ? 32'hFFFF_FFFF : mem_readdata;
                    if (abort) m_err = 1'b1;
                    if (cur.is_data) begin
                        dv_n = 1'b1;
                        if (!cur.is_write || abort) m_drd = r;
                    end else begin
                        iv_n = 1'b1;
                        m_ird = r;
                    end
                    cur.active = 1'b0;
                end else begin
                    cur.waited++;
                end
            end else if ((data_read || data_write) && !m_dv) begin
                cur.active   = 1'b1;
                cur.is_data  = 1'b1;
                cur.is_write = data_write;
                cur.addr     = data_address;
                cur.wdata    = data_writedata;
                cur.be       = data_write ? data_byteenable : 4'b1111;
                cur.waited   = 0;
                if (data_read && data_write) m_err = 1'b1;
            end else if (instr_read && !m_iv) begin
                cur.active   = 1'b1;
                cur.is_data  = 1'b0;
                cur.is_write = 1'b0;
                cur.addr     = instr_address;
                cur.wdata    = '0;
                cur.be       = 4'b1111;
                cur.waited   = 0;
            end
            m_iv = iv_n;
            m_dv = dv_n;
        end
    end

    // Every cycle compare the DUT with the reference, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mem_read", {31'd0, mem_read}, {31'd0, cur.active && !cur.is_write});
            chk("mem_write", {31'd0, mem_write}, {31'd0, cur.active && cur.is_write});
            if (cur.active) begin
                chk("mem_address", mem_address, cur.addr);
                chk("mem_byteenable", {28'd0, mem_byteenable}, {28'd0, cur.be});
                if (cur.is_write) chk("mem_writedata", mem_writedata, cur.wdata);
            end
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
            chk("data_valid", {31'd0, data_valid}, {31'd0, m_dv});
            chk("instr_readdata", instr_readdata, m_ird);
            chk("data_readdata", data_readdata, m_drd);
            chk("bus_error", {31'd0, bus_error}, {31'd0, m_err});
            chk("cpu_stall", {31'd0, cpu_stall},
                {31'd0, !reset && ((instr_read && !m_iv) || ((data_read || data_write) && !m_dv))});
        end
    end

    initial begin
        reset = 1'b1;
        instr_address = '0; instr_read = 1'b0;
        data_address = '0; data_read = 1'b0; data_write = 1'b0;
        data_writedata = '0; data_byteenable = '0;
        mem_readdata = '0; mem_waitrequest = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        chk("rst_mem_byteenable", {28'd0, mem_byteenable}, 32'd0);
        chk("rst_valids", {30'd0, instr_valid, data_valid}, 32'd0);
        chk("rst_readdata", instr_readdata | data_readdata, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        cmp_en = 1'b1;
        reset = 1'b0;
        step();

        // Single fetch, no wait states
        instr_address = 32'hBFC0_0000; instr_read = 1'b1;
        mem_readdata = 32'h2402_0005; mem_waitrequest = 1'b0;
        #1;
        chk("t1_stall_n0", {31'd0, cpu_stall}, 32'd1);
        step();
        chk("t1_mem_read", {31'd0, mem_read}, 32'd1);
        chk("t1_mem_address", mem_address, 32'hBFC0_0000);
        chk("t1_stall_n1", {31'd0, cpu_stall}, 32'd1);
        chk("t1_no_early_valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("t1_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr_readdata", instr_readdata, 32'h2402_0005);
        chk("t1_strobe_drop", {31'd0, mem_read}, 32'd0);
        chk("t1_stall_n2", {31'd0, cpu_stall}, 32'd0);
        chk("t1_model_ird", m_ird, 32'h2402_0005);
        instr_read = 1'b0;
        step();
        chk("t1_valid_one_cycle", {31'd0, instr_valid}, 32'd0);

        // Contention: data wins, fetch follows after an IDLE cycle
        data_address = 32'h0000_1000; data_read = 1'b1;
        instr_address = 32'h0040_0000; instr_read = 1'b1;
        mem_readdata = 32'h1111_1111;
        step();
        chk("t2_data_first", {31'd0, mem_read}, 32'd1);
        chk("t2_data_addr", mem_address, 32'h0000_1000);
        step();
        chk("t2_data_valid", {31'd0, data_valid}, 32'd1);
        chk("t2_no_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("t2_data_readdata", data_readdata, 32'h1111_1111);
        chk("t2_idle_gap", {31'd0, mem_read}, 32'd0);
        data_read = 1'b0;
        mem_readdata = 32'h2222_2222;
        step();
        chk("t2_fetch_issued", {31'd0, mem_read}, 32'd1);
        chk("t2_fetch_addr", mem_address, 32'h0040_0000);
        chk("t2_data_valid_once", {31'd0, data_valid}, 32'd0);
        step();
        chk("t2_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("t2_instr_readdata", instr_readdata, 32'h2222_2222);
        instr_read = 1'b0;
        step();
        chk("t2_instr_valid_once", {31'd0, instr_valid}, 32'd0);

        // Write with three wait states
        data_address = 32'h0000_2000; data_write = 1'b1;
        data_writedata = 32'hDEAD_BEEF; data_byteenable = 4'b0011;
        mem_waitrequest = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t3_mem_write", {31'd0, mem_write}, 32'd1);
            chk("t3_mem_address", mem_address, 32'h0000_2000);
            chk("t3_mem_writedata", mem_writedata, 32'hDEAD_BEEF);
            chk("t3_mem_byteenable", {28'd0, mem_byteenable}, 32'h3);
            chk("t3_no_valid", {31'd0, data_valid}, 32'd0);
            if (k == 4) mem_waitrequest = 1'b0;
        end
        step();
        chk("t3_data_valid", {31'd0, data_valid}, 32'd1);
        chk("t3_readdata_kept", data_readdata, 32'h1111_1111);
        chk("t3_strobe_drop", {31'd0, mem_write}, 32'd0);
        data_write = 1'b0;
        step();
        chk("t3_valid_once", {31'd0, data_valid}, 32'd0);

        // Timeout on a fetch
        instr_address = 32'h0000_3000; instr_read = 1'b1; mem_waitrequest = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t4_mem_read_held", {31'd0, mem_read}, 32'd1);
            chk("t4_no_valid", {31'd0, instr_valid}, 32'd0);
        end
        step();
        chk("t4_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("t4_readdata_ones", instr_readdata, 32'hFFFF_FFFF);
        chk("t4_bus_error", {31'd0, bus_error}, 32'd1);
        chk("t4_strobe_drop", {31'd0, mem_read}, 32'd0);
        chk("t4_model_err", {31'd0, m_err}, 32'd1);
        instr_read = 1'b0; mem_waitrequest = 1'b0;
        repeat (3) step();
        chk("t4_error_sticky", {31'd0, bus_error}, 32'd1);

        // Reset while a data read is stalled
        data_address = 32'h0000_4000; data_read = 1'b1; mem_waitrequest = 1'b1;
        step();
        chk("t5_mem_read", {31'd0, mem_read}, 32'd1);
        step();
        reset = 1'b1;
        #1;
        chk("t5_stall_in_reset", {31'd0, cpu_stall}, 32'd0);
        step();
        chk("t5_mem_read_clr", {31'd0, mem_read}, 32'd0);
        chk("t5_data_valid_clr", {31'd0, data_valid}, 32'd0);
        chk("t5_bus_error_clr", {31'd0, bus_error}, 32'd0);
        reset = 1'b0; data_read = 1'b0; mem_waitrequest = 1'b0;
        repeat (4) begin
            step();
            chk("t5_no_late_valid", {31'd0, data_valid}, 32'd0);
            chk("t5_no_reissue", {31'd0, mem_read}, 32'd0);
        end

        // Read and write together: served as a write and flagged
        data_address = 32'h0000_5000; data_read = 1'b1; data_write = 1'b1;
        data_writedata = 32'h0BAD_F00D; data_byteenable = 4'b1111;
        step();
        chk("t6_mem_write", {31'd0, mem_write}, 32'd1);
        chk("t6_mem_read", {31'd0, mem_read}, 32'd0);
        chk("t6_mem_address", mem_address, 32'h0000_5000);
        step();
        chk("t6_data_valid", {31'd0, data_valid}, 32'd1);
        chk("t6_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("t6_bus_error", {31'd0, bus_error}, 32'd1);
        chk("t6_readdata_kept", data_readdata, 32'd0);
        data_read = 1'b0; data_write = 1'b0;
        step();

        // Randomised traffic checked cycle by cycle against the reference
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (instr_read && instr_valid) begin
                instr_read = 1'($urandom_range(0, 1));
                instr_address = $urandom;
            end else if (!instr_read) begin
                if ($urandom_range(0, 2) == 0) begin
                    instr_read = 1'b1;
                    instr_address = $urandom;
                end
            end else if ($urandom_range(0, 49) == 0) begin
                instr_read = 1'b0;
            end
            if ((data_read || data_write) && data_valid) begin
                data_read = 1'b0;
                data_write = 1'b0;
            end else if (!(data_read || data_write)) begin
                if ($urandom_range(0, 2) == 0) begin
                    int kind;
                    kind = $urandom_range(0, 19);
                    data_read = (kind < 9) || (kind == 19);
                    data_write = (kind >= 9);
                    data_address = $urandom;
                    data_writedata = $urandom;
                    data_byteenable = 4'($urandom_range(1, 15));
                end
            end else if ($urandom_range(0, 49) == 0) begin
                data_read = 1'b0;
                data_write = 1'b0;
            end
            mem_waitrequest = ($urandom_range(0, 9) < 3);
            mem_readdata = $urandom;
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0;
        step();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
